// File: rtl/syn_i2s_adc_tx.sv
// syn_i2s_adc_tx: I2S slave transmitter emulating the ADC side of a codec.
// bclk/lrc are oversampled in the clk_ir domain; a one-pair holding buffer feeds the L/R shifters.
module syn_i2s_adc_tx #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2,
   parameter int UFLOW_CNT_W = 16
) (
   input  logic                   clk_ir,
   input  logic                   sys_rst_ih,
   input  logic                   en_ih,
   input  logic [DATA_W-1:0]      pcm_lchnl_id,
   input  logic [DATA_W-1:0]      pcm_rchnl_id,
   input  logic                   pcm_valid_ih,
   output logic                   pcm_ready_oh,
   input  logic                   bclk_ir,
   input  logic                   lrc_ir,
   output logic                   adc_dat_od,
   output logic                   uflow_oh,
   output logic [UFLOW_CNT_W-1:0] uflow_cnt_od
);

   localparam int BIT_CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] bclk_sync_r;
   logic [SYNC_STAGES-1:0] lrc_sync_r;
   logic                   bclk_prev_r;
   logic                   bclk_fall_r;
   logic                   lrc_at_fall_r;
   logic                   lrc_last_r;

   logic                   buf_full_r;
   logic [DATA_W-1:0]      buf_l_r;
   logic [DATA_W-1:0]      buf_r_r;
   logic                   ready_r;

   state_t                 state_r;
   logic [DATA_W-1:0]      shift_r;
   logic [DATA_W-1:0]      rsamp_r;
   logic [BIT_CNT_W-1:0]   bits_left_r;
   logic                   adc_dat_r;
   logic                   uflow_r;
   logic [UFLOW_CNT_W-1:0] uflow_cnt_r;

   logic                   lrc_rise_s;
   logic                   lrc_fall_s;
   logic                   frame_start_s;
   logic                   push_s;
   logic                   bypass_s;
   logic                   load_buf_s;
   logic                   drain_s;
   logic                   uflow_s;
   logic                   buf_full_nxt_s;
   logic                   shift_bit_s;
   logic [DATA_W-1:0]      frame_l_s;
   logic [DATA_W-1:0]      frame_r_s;

   // Synchroniser chains for the asynchronous bclk/lrc pins
   always_ff @(posedge clk_ir or posedge sys_rst_ih) begin
      if (sys_rst_ih) begin
         bclk_sync_r <= '0;
         lrc_sync_r  <= '0;
      end else begin
         bclk_sync_r[0] <= bclk_ir;
         lrc_sync_r[0]  <= lrc_ir;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            bclk_sync_r[i] <= bclk_sync_r[i-1];
            lrc_sync_r[i]  <= lrc_sync_r[i-1];
         end
      end
   end

   // Registered bclk fall detect; lrc is captured alongside so each fall sees a consistent lrc
   always_ff @(posedge clk_ir or posedge sys_rst_ih) begin
      if (sys_rst_ih) begin
         bclk_prev_r   <= 1'b0;
         bclk_fall_r   <= 1'b0;
         lrc_at_fall_r <= 1'b0;
         lrc_last_r    <= 1'b0;
      end else begin
         bclk_prev_r   <= bclk_sync_r[SYNC_STAGES-1];
         bclk_fall_r   <= bclk_prev_r & ~bclk_sync_r[SYNC_STAGES-1];
         lrc_at_fall_r <= lrc_sync_r[SYNC_STAGES-1];
         if (bclk_fall_r) begin
            lrc_last_r <= lrc_at_fall_r;
         end
      end
   end

   // Event decode, handshake and frame-start source selection
   always_comb begin
      lrc_rise_s    = bclk_fall_r & ~lrc_last_r & lrc_at_fall_r;
      lrc_fall_s    = bclk_fall_r & lrc_last_r & ~lrc_at_fall_r;
      frame_start_s = en_ih & lrc_fall_s;
      push_s        = pcm_valid_ih & ready_r;
      bypass_s      = frame_start_s & ~buf_full_r & push_s;
      load_buf_s    = push_s & ~bypass_s;
      drain_s       = frame_start_s & buf_full_r;
      uflow_s       = frame_start_s & ~buf_full_r & ~push_s;
      shift_bit_s   = (bits_left_r != {BIT_CNT_W{1'b0}}) ? shift_r[DATA_W-1] : 1'b0;

      if (drain_s) begin
         buf_full_nxt_s = 1'b0;
      end else if (load_buf_s) begin
         buf_full_nxt_s = 1'b1;
      end else begin
         buf_full_nxt_s = buf_full_r;
      end

      if (buf_full_r) begin
         frame_l_s = buf_l_r;
         frame_r_s = buf_r_r;
      end else if (bypass_s) begin
         frame_l_s = pcm_lchnl_id;
         frame_r_s = pcm_rchnl_id;
      end else begin
         frame_l_s = {DATA_W{1'b0}};
         frame_r_s = {DATA_W{1'b0}};
      end
   end

   // One-pair holding buffer; ready mirrors the next fill state so it drops the cycle after a fill
   always_ff @(posedge clk_ir or posedge sys_rst_ih) begin
      if (sys_rst_ih) begin
         buf_full_r <= 1'b0;
         buf_l_r    <= {DATA_W{1'b0}};
         buf_r_r    <= {DATA_W{1'b0}};
         ready_r    <= 1'b1;
      end else begin
         buf_full_r <= buf_full_nxt_s;
         ready_r    <= ~buf_full_nxt_s;
         if (load_buf_s) begin
            buf_l_r <= pcm_lchnl_id;
            buf_r_r <= pcm_rchnl_id;
         end
      end
   end

   // Frame FSM and serialiser, advanced only on bclk fall events
   always_ff @(posedge clk_ir or posedge sys_rst_ih) begin
      if (sys_rst_ih) begin
         state_r     <= ST_IDLE;
         shift_r     <= {DATA_W{1'b0}};
         rsamp_r     <= {DATA_W{1'b0}};
         bits_left_r <= {BIT_CNT_W{1'b0}};
         adc_dat_r   <= 1'b0;
         uflow_r     <= 1'b0;
         uflow_cnt_r <= {UFLOW_CNT_W{1'b0}};
      end else begin
         uflow_r <= 1'b0;
         if (!en_ih) begin
            state_r     <= ST_IDLE;
            adc_dat_r   <= 1'b0;
            bits_left_r <= {BIT_CNT_W{1'b0}};
         end else if (bclk_fall_r) begin
            if (lrc_fall_s) begin
               // Frame start from any state; this fall is the I2S one-bit delay slot
               state_r     <= ST_LEFT;
               adc_dat_r   <= 1'b0;
               shift_r     <= frame_l_s;
               rsamp_r     <= frame_r_s;
               bits_left_r <= BIT_CNT_W'(DATA_W);
               if (uflow_s) begin
                  uflow_r <= 1'b1;
                  if (uflow_cnt_r != {UFLOW_CNT_W{1'b1}}) begin
                     uflow_cnt_r <= uflow_cnt_r + {{(UFLOW_CNT_W-1){1'b0}}, 1'b1};
                  end
               end
            end else begin
               case (state_r)
                  ST_LEFT: begin
                     if (lrc_rise_s) begin
                        state_r     <= ST_RIGHT;
                        adc_dat_r   <= 1'b0;
                        shift_r     <= rsamp_r;
                        bits_left_r <= BIT_CNT_W'(DATA_W);
                     end else begin
                        adc_dat_r <= shift_bit_s;
                        if (bits_left_r != {BIT_CNT_W{1'b0}}) begin
                           shift_r     <= {shift_r[DATA_W-2:0], 1'b0};
                           bits_left_r <= bits_left_r - BIT_CNT_W'(1);
                        end
                     end
                  end
                  ST_RIGHT: begin
                     adc_dat_r <= shift_bit_s;
                     if (bits_left_r != {BIT_CNT_W{1'b0}}) begin
                        shift_r     <= {shift_r[DATA_W-2:0], 1'b0};
                        bits_left_r <= bits_left_r - BIT_CNT_W'(1);
                     end
                  end
                  default: begin
                     state_r   <= ST_IDLE;
                     adc_dat_r <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

   assign pcm_ready_oh = ready_r;
   assign adc_dat_od   = adc_dat_r;
   assign uflow_oh     = uflow_r;
   assign uflow_cnt_od = uflow_cnt_r;

endmodule

// File: tb/tb_syn_i2s_adc_tx.sv
// tb_syn_i2s_adc_tx: scoreboard bench for the I2S ADC-side transmitter.
// Expected serial bits are queued per slot and popped on every bclk fall.
module tb_syn_i2s_adc_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rst2, en, en2, valid, valid2, bclk, lrc;
   logic [15:0] pl, pr;
   logic        ready, adc, uflow;
   logic [15:0] cnt;
   logic        ready2, adc2, uflow2;
   logic [1:0]  cnt2;

   int   checks = 0;
   int   failures = 0;
   int   uflow_seen = 0;
   int   uflow2_seen = 0;
   int   exp_uflow = 0;
   logic exp_q[$];
   logic last_bit = 1'b0;

   syn_i2s_adc_tx #(.DATA_W(16), .SYNC_STAGES(2), .UFLOW_CNT_W(16)) dut (
      .clk_ir(clk), .sys_rst_ih(rst), .en_ih(en),
      .pcm_lchnl_id(pl), .pcm_rchnl_id(pr), .pcm_valid_ih(valid), .pcm_ready_oh(ready),
      .bclk_ir(bclk), .lrc_ir(lrc), .adc_dat_od(adc),
      .uflow_oh(uflow), .uflow_cnt_od(cnt)
   );

   syn_i2s_adc_tx #(.DATA_W(16), .SYNC_STAGES(2), .UFLOW_CNT_W(2)) dut2 (
      .clk_ir(clk), .sys_rst_ih(rst2), .en_ih(en2),
      .pcm_lchnl_id(pl), .pcm_rchnl_id(pr), .pcm_valid_ih(valid2), .pcm_ready_oh(ready2),
      .bclk_ir(bclk), .lrc_ir(lrc), .adc_dat_od(adc2),
      .uflow_oh(uflow2), .uflow_cnt_od(cnt2)
   );

   // Pulse counters for the underflow strobes
   always @(negedge clk) begin
      if (uflow === 1'b1) uflow_seen <= uflow_seen + 1;
      if (uflow2 === 1'b1) uflow2_seen <= uflow2_seen + 1;
   end

   // One bclk period; hook 1 = bypass push on the frame-start cycle, hook 2 = ready edge check
   task automatic bclk_fall(input logic lrc_val, input int hook);
      logic e;
      @(negedge clk);
      bclk = 1'b0;
      lrc  = lrc_val;
      repeat (3) @(negedge clk);
      if (hook == 1) begin
         checks++;
         if (ready !== 1'b1) begin
            failures++;
            $display("FAIL bypass_ready: got %b want 1", ready);
         end
         valid = 1'b1;
      end
      if (hook == 2) begin
         checks++;
         if (ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_frame_start: got %b want 0", ready);
         end
      end
      checks++;
      if (adc !== last_bit) begin
         failures++;
         $display("FAIL adc_latency_hold: got %b want %b at %0t", adc, last_bit, $time);
      end
      @(negedge clk);
      if (hook == 1) valid = 1'b0;
      if (hook == 2) begin
         checks++;
         if (ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_frame_start: got %b want 1", ready);
         end
      end
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty: got 0 entries want >=1");
         e = 1'b0;
      end else begin
         e = exp_q.pop_front();
      end
      checks++;
      if (adc !== e) begin
         failures++;
         $display("FAIL adc_bit: got %b want %b at %0t", adc, e, $time);
      end
      last_bit = e;
      repeat (4) @(negedge clk);
      bclk = 1'b1;
      repeat (7) @(negedge clk);
   endtask

   task automatic run_slot(input logic lrc_val, input int nb, input logic [15:0] word, input int hook0);
      for (int i = 0; i < nb; i++) exp_q.push_back((i >= 1 && i <= 16) ? word[16-i] : 1'b0);
      for (int i = 0; i < nb; i++) bclk_fall(lrc_val, (i == 0) ? hook0 : 0);
   endtask

   task automatic run_frame(input int nb, input logic [15:0] l, input logic [15:0] r, input int hook0);
      run_slot(1'b0, nb, l, hook0);
      run_slot(1'b1, nb, r, 0);
   endtask

   task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
      int n = 0;
      @(negedge clk);
      while (ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL push_timeout: got ready=%b want 1", ready);
      end else begin
         pl = l;
         pr = r;
         valid = 1'b1;
         @(negedge clk);
         valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks += 4;
      if (ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", ready); end
      if (adc !== 1'b0) begin failures++; $display("FAIL rst_adc: got %b want 0", adc); end
      if (uflow !== 1'b0) begin failures++; $display("FAIL rst_uflow: got %b want 0", uflow); end
      if (cnt !== 16'h0000) begin failures++; $display("FAIL rst_cnt: got %h want 0000", cnt); end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checks += 4;
      if (ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready: got %b want 1", ready); end
      if (adc !== 1'b0) begin failures++; $display("FAIL post_rst_adc: got %b want 0", adc); end
      if (ready2 !== 1'b1) begin failures++; $display("FAIL rst2_ready: got %b want 1", ready2); end
      if (cnt2 !== 2'd0) begin failures++; $display("FAIL rst2_cnt: got %0d want 0", cnt2); end
   endtask

   task automatic test_basic();
      en = 1'b1;
      push_pair(16'hA55A, 16'h1234);
      run_slot(1'b1, 4, 16'h0000, 0);
      run_frame(32, 16'hA55A, 16'h1234, 0);
      checks += 2;
      if (uflow_seen !== exp_uflow) begin failures++; $display("FAIL basic_uflow: got %0d want %0d", uflow_seen, exp_uflow); end
      if (cnt !== 16'd0) begin failures++; $display("FAIL basic_cnt: got %0d want 0", cnt); end
   endtask

   task automatic test_underflow();
      for (int k = 1; k <= 3; k++) begin
         run_frame(32, 16'h0000, 16'h0000, 0);
         exp_uflow++;
         checks += 2;
         if (uflow_seen !== exp_uflow) begin failures++; $display("FAIL uflow_pulses: got %0d want %0d", uflow_seen, exp_uflow); end
         if (cnt !== 16'(k)) begin failures++; $display("FAIL uflow_cnt: got %0d want %0d", cnt, k); end
      end
   endtask

   task automatic test_back_to_back();
      push_pair(16'h8E71, 16'h0F1E);
      checks++;
      if (ready !== 1'b0) begin failures++; $display("FAIL ready_after_fill: got %b want 0", ready); end
      repeat (5) @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin failures++; $display("FAIL ready_held_low: got %b want 0", ready); end
      run_slot(1'b0, 32, 16'h8E71, 2);
      push_pair(16'hB00C, 16'h7531);
      run_slot(1'b1, 32, 16'h0F1E, 0);
      run_frame(32, 16'hB00C, 16'h7531, 0);
      pl = 16'hD2C4;
      pr = 16'h9ABF;
      run_frame(32, 16'hD2C4, 16'h9ABF, 1);
      checks += 3;
      if (uflow_seen !== exp_uflow) begin failures++; $display("FAIL b2b_uflow: got %0d want %0d", uflow_seen, exp_uflow); end
      if (cnt !== 16'd3) begin failures++; $display("FAIL b2b_cnt: got %0d want 3", cnt); end
      if (ready !== 1'b1) begin failures++; $display("FAIL bypass_buffer_empty: got %b want 1", ready); end
   endtask

   task automatic test_short_slot();
      push_pair(16'hFFFF, 16'h8001);
      run_frame(12, 16'hFFFF, 16'h8001, 0);
      push_pair(16'hC3A5, 16'h5A3C);
      run_frame(32, 16'hC3A5, 16'h5A3C, 0);
      checks++;
      if (cnt !== 16'd3) begin failures++; $display("FAIL short_cnt: got %0d want 3", cnt); end
   endtask

   task automatic test_reset_mid();
      push_pair(16'h0F0F, 16'h7E81);
      run_slot(1'b0, 8, 16'h0F0F, 0);
      push_pair(16'hAAAA, 16'h5555);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks += 4;
      if (adc !== 1'b0) begin failures++; $display("FAIL midrst_adc: got %b want 0", adc); end
      if (ready !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b want 1", ready); end
      if (cnt !== 16'd0) begin failures++; $display("FAIL midrst_cnt: got %0d want 0", cnt); end
      if (uflow !== 1'b0) begin failures++; $display("FAIL midrst_uflow: got %b want 0", uflow); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      last_bit = 1'b0;
      run_slot(1'b0, 10, 16'h0000, 0);
      run_slot(1'b1, 32, 16'h0000, 0);
      checks += 2;
      if (cnt !== 16'd0) begin failures++; $display("FAIL partial_cnt: got %0d want 0", cnt); end
      if (uflow_seen !== exp_uflow) begin failures++; $display("FAIL partial_uflow: got %0d want %0d", uflow_seen, exp_uflow); end
      push_pair(16'h3C96, 16'hE1D2);
      run_frame(32, 16'h3C96, 16'hE1D2, 0);
      checks++;
      if (cnt !== 16'd0) begin failures++; $display("FAIL resume_cnt: got %0d want 0", cnt); end
   endtask

   task automatic test_enable();
      push_pair(16'hFC00, 16'h1248);
      run_slot(1'b0, 6, 16'hFC00, 0);
      en = 1'b0;
      @(negedge clk);
      checks++;
      if (adc !== 1'b0) begin failures++; $display("FAIL disable_adc: got %b want 0", adc); end
      last_bit = 1'b0;
      run_frame(32, 16'h0000, 16'h0000, 0);
      run_frame(32, 16'h0000, 16'h0000, 0);
      checks += 2;
      if (uflow_seen !== exp_uflow) begin failures++; $display("FAIL disabled_uflow: got %0d want %0d", uflow_seen, exp_uflow); end
      if (cnt !== 16'd0) begin failures++; $display("FAIL disabled_cnt: got %0d want 0", cnt); end
      push_pair(16'h6DB6, 16'h1357);
      en = 1'b1;
      run_frame(32, 16'h6DB6, 16'h1357, 0);
      checks += 2;
      if (uflow_seen !== exp_uflow) begin failures++; $display("FAIL reenable_uflow: got %0d want %0d", uflow_seen, exp_uflow); end
      if (cnt !== 16'd0) begin failures++; $display("FAIL reenable_cnt: got %0d want 0", cnt); end
   endtask

   task automatic test_uflow_sat();
      logic [1:0] exp_c;
      en = 1'b0;
      @(negedge clk);
      rst2 = 1'b0;
      en2 = 1'b1;
      run_slot(1'b1, 2, 16'h0000, 0);
      for (int k = 1; k <= 5; k++) begin
         run_frame(32, 16'h0000, 16'h0000, 0);
         exp_c = (k < 3) ? 2'(k) : 2'd3;
         checks += 2;
         if (uflow2_seen !== k) begin failures++; $display("FAIL sat_pulses: got %0d want %0d", uflow2_seen, k); end
         if (cnt2 !== exp_c) begin failures++; $display("FAIL sat_cnt: got %0d want %0d", cnt2, exp_c); end
      end
      en2 = 1'b0;
      run_frame(32, 16'h0000, 16'h0000, 0);
      checks += 4;
      if (uflow2_seen !== 5) begin failures++; $display("FAIL sat_disabled_pulses: got %0d want 5", uflow2_seen); end
      if (cnt2 !== 2'd3) begin failures++; $display("FAIL sat_disabled_cnt: got %0d want 3", cnt2); end
      if (adc2 !== 1'b0) begin failures++; $display("FAIL sat_adc: got %b want 0", adc2); end
      if (uflow_seen !== exp_uflow) begin failures++; $display("FAIL sat_dut1_uflow: got %0d want %0d", uflow_seen, exp_uflow); end
   endtask

   initial begin
      rst = 1'b1;
      rst2 = 1'b1;
      en = 1'b0;
      en2 = 1'b0;
      valid = 1'b0;
      valid2 = 1'b0;
      bclk = 1'b1;
      lrc = 1'b1;
      pl = 16'h0000;
      pr = 16'h0000;
      test_reset();
      test_basic();
      test_underflow();
      test_back_to_back();
      test_short_slot();
      test_reset_mid();
      test_enable();
      test_uflow_sat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
